// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
// State TAG is only reachable when UART_TX_ARB_TAG_EN is defined.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Header byte base; the grantee index is OR-ed into the low bits.
    localparam logic [7:0] TAG_BASE = 8'hF0;

    // Legal requester count range.
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// at or after the pointer, wrapping around to index 0.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_ptr,
    output logic [GW-1:0]      o_win,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_vec;
    logic               w_found;

    // Requests at or above the pointer take priority; otherwise wrap to
    // the full vector. Lowest set bit of the chosen vector wins.
    always_comb begin
        w_hi    = '0;
        w_found = 1'b0;
        o_win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_hi[i] = i_req[i] && (i >= 32'(i_ptr));
        end
        w_vec = (|w_hi) ? w_hi : i_req;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_vec[i] && !w_found) begin
                w_found = 1'b1;
                o_win   = GW'(i);
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte port among
// NUM_REQ byte-stream requesters. A grant is held until a byte with
// req_last transfers or MAX_BURST bytes have gone out.
// Optional feature macro: UART_TX_ARB_TAG_EN (emit header byte 0xF0|id
// before each grant's data).
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int MAX_BURST = 16,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    localparam int              BW         = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
        MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ or MAX_BURST out of range");
    end

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_ptr;
    logic [BW-1:0]   r_burst;

    logic [GW-1:0]   w_win;
    logic            w_any;
    logic            w_sel_valid;
    logic            w_sel_last;
    logic [7:0]      w_sel_data;
    logic            w_xfer;
    logic            w_release;
    logic [GW-1:0]   w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    // Select the current grantee's lane (valid, last, data).
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign w_xfer     = (r_state == ST_XFER) && w_sel_valid && tx_ready;
    assign w_release  = w_xfer && (w_sel_last || (r_burst == BURST_LAST));
    assign w_ptr_next = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    // Arbitration FSM, grant register, burst counter and rotation pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_burst <= '0;
`ifdef UART_TX_ARB_TAG_EN
                        r_state <= ST_TAG;
`else
                        r_state <= ST_XFER;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                ST_TAG: begin
                    if (tx_ready) r_state <= ST_XFER;
                end
`endif
                ST_XFER: begin
                    if (w_xfer) begin
                        r_burst <= r_burst + 1'b1;
                        if (w_release) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_ptr_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Byte-path muxing: combinational pass-through while granted.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (r_state)
`ifdef UART_TX_ARB_TAG_EN
            ST_TAG: begin
                tx_valid = 1'b1;
                tx_data  = TAG_BASE | 8'(r_grant);
            end
`endif
            ST_XFER: begin
                tx_valid = w_sel_valid;
                tx_data  = w_sel_data;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (r_grant == GW'(i)) && tx_ready;
                end
            end
            default: ;
        endcase
    end

    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);

endmodule
